coin_credit_ctrl: RTL and testbench

//  Front-end for arcade play. Synchronises and debounces the raw coin switch,

---
 rtl/qbert_pkg.sv | 15 +
 rtl/btn_debounce.sv | 72 +++++++
 rtl/coin_credit_ctrl.sv | 104 ++++++++++
 tb/tb_coin_credit_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qbert_pkg.sv
// Shared types and default sizing for the coin/credit front-end.
package qbert_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CREDIT_W_DEF        = 4;
    localparam int MAX_CREDITS_DEF     = 9;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } deb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-FF synchroniser plus debounce FSM for a bouncy active-high switch.
// Emits a single-cycle press strobe once the level has been stable high.
module btn_debounce
    import qbert_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous switch level into the clock domain.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Debounce FSM: the synced level must hold for DEBOUNCE_CYCLES in each direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sync2) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2)               state <= IDLE;
                    else if (cnt == CNT_LAST) state <= HELD;
                    else                      cnt   <= cnt + 1'b1;
                end
                HELD: begin
                    if (!sync2) begin
                        state <= REL_WAIT;
                        cnt   <= '0;
                    end
                end
                REL_WAIT: begin
                    if (sync2)                state <= HELD;
                    else if (cnt == CNT_LAST) state <= IDLE;
                    else                      cnt   <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobe is a decode of registered state only, so the consumer can register
    // its response on the same edge the FSM enters HELD.
    assign press = (state == PRESS_WAIT) && sync2 && (cnt == CNT_LAST);

endmodule

// File: rtl/coin_credit_ctrl.sv
// Arcade coin/credit front-end: debounced coin accept, saturating credit count,
// game-start grant/refuse, synchronised arcade/free-play mode.
module coin_credit_ctrl
    import qbert_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CREDIT_W        = CREDIT_W_DEF,
    parameter int MAX_CREDITS     = MAX_CREDITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_btn,
    input  logic                arcade_sw,
    input  logic                start_req,
    output logic                e_piece,
    output logic                coin_reject,
    output logic                start_ack,
    output logic                start_nack,
    output logic [CREDIT_W-1:0] credits,
    output logic                mode_arcade
);

    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDITS);

    logic mode_sync1;
    logic mode_d;
    logic coin_press;

    logic                accept_n;
    logic                reject_n;
    logic                ack_n;
    logic                nack_n;
    logic [CREDIT_W-1:0] credits_n;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_coin_deb (
        .clk  (clk),
        .reset(reset),
        .btn  (coin_btn),
        .press(coin_press)
    );

    // Mode switch synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_sync1  <= 1'b0;
            mode_arcade <= 1'b0;
            mode_d      <= 1'b0;
        end else begin
            mode_sync1  <= arcade_sw;
            mode_arcade <= mode_sync1;
            mode_d      <= mode_arcade;
        end
    end

    // Coin/start arbitration against the current registered credits and mode.
    // A coin arriving with a start request funds that game directly, so it is
    // accepted even at MAX and the count is left unchanged.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        accept_n  = 1'b0;
        reject_n  = 1'b0;
        ack_n     = 1'b0;
        nack_n    = 1'b0;
        credits_n = credits;

        if (coin_press && mode_arcade) begin
            if (start_req || (credits < MAX_C)) accept_n = 1'b1;
            else                                reject_n = 1'b1;
        end

        if (start_req) begin
            if (!mode_arcade || (coin_press || (credits != '0))) ack_n  = 1'b1;
            else                                                  nack_n = 1'b1;
        end

        if (mode_arcade) begin
            if (accept_n && !(ack_n && start_req))       credits_n = credits + 1'b1;
            else if (ack_n && !accept_n)                 credits_n = credits - 1'b1;
        end

        // Leaving arcade mode wipes the credits, overriding any same-cycle update.
        if (mode_d && !mode_arcade) credits_n = '0;
    end

    // Registered credit count and single-cycle output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits     <= '0;
            e_piece     <= 1'b0;
            coin_reject <= 1'b0;
            start_ack   <= 1'b0;
            start_nack  <= 1'b0;
        end else begin
            credits     <= credits_n;
            e_piece     <= accept_n;
            coin_reject <= reject_n;
            start_ack   <= ack_n;
            start_nack  <= nack_n;
        end
    end

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Scoreboard bench for coin_credit_ctrl with DEBOUNCE_CYCLES=4, MAX_CREDITS=3.
// Pulse codes are {e_piece, coin_reject, start_ack, start_nack}.
module tb_coin_credit_ctrl;

    localparam logic [3:0] P_E = 4'b1000;
    localparam logic [3:0] P_R = 4'b0100;
    localparam logic [3:0] P_A = 4'b0010;
    localparam logic [3:0] P_N = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] pulses;
        logic [3:0] credits;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_btn = 1'b0;
    logic       arcade_sw = 1'b0;
    logic       start_req = 1'b0;
    logic       e_piece, coin_reject, start_ack, start_nack, mode_arcade;
    logic [3:0] credits;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    coin_credit_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CREDIT_W       (4),
        .MAX_CREDITS    (3)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .coin_btn   (coin_btn),
        .arcade_sw  (arcade_sw),
        .start_req  (start_req),
        .e_piece    (e_piece),
        .coin_reject(coin_reject),
        .start_ack  (start_ack),
        .start_nack (start_nack),
        .credits    (credits),
        .mode_arcade(mode_arcade)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect a pulse set visible off cycles after the current edge.
    task automatic expect_pulse(input int off, input logic [3:0] p, input logic [3:0] c);
        exp_t e;
        e.cyc     = cyc + off;
        e.pulses  = p;
        e.credits = c;
        sb_q.push_back(e);
    endtask

    // Clean press: coin driven just after edge k is first sampled at k+1,
    // so the response shows in the cycle after edge k+7.
    task automatic clean_press(input logic [3:0] p, input logic [3:0] c);
        if (p != 4'b0000) expect_pulse(7, p, c);
        coin_btn = 1'b1;
        tick(8);
        coin_btn = 1'b0;
        tick(12);
    endtask

    task automatic start_pulse(input logic [3:0] p, input logic [3:0] c);
        expect_pulse(1, p, c);
        start_req = 1'b1;
        tick(1);
        start_req = 1'b0;
        tick(2);
    endtask

    // Coin strobe and start request land on the same edge.
    task automatic coin_with_start(input logic [3:0] c);
        expect_pulse(7, P_E | P_A, c);
        coin_btn = 1'b1;
        tick(6);
        start_req = 1'b1;
        tick(1);
        start_req = 1'b0;
        tick(2);
        coin_btn = 1'b0;
        tick(12);
    endtask

    // Monitor: any pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [3:0] p;
        exp_t       e;
        p = {e_piece, coin_reject, start_ack, start_nack};
        if (!reset && (p != 4'b0000)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", int'(p), 0);
            end else begin
                e = sb_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_kind", int'(p), int'(e.pulses));
                check("pulse_credits", int'(credits), int'(e.credits));
            end
        end
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_pulses", int'({e_piece, coin_reject, start_ack, start_nack}), 0);
        check("rst_credits", int'(credits), 0);
        check("rst_mode", int'(mode_arcade), 0);
        reset = 1'b0;
        arcade_sw = 1'b1;
        tick(4);
        check("mode_arcade_on", int'(mode_arcade), 1);

        // 1: long press gives one pulse, none on release
        expect_pulse(7, P_E, 4'd1);
        coin_btn = 1'b1;
        tick(20);
        coin_btn = 1'b0;
        tick(14);
        check("t1_credits", int'(credits), 1);

        // 2: bouncing input never qualifies
        for (int i = 0; i < 3; i++) begin
            coin_btn = 1'b1;
            tick(2);
            coin_btn = 1'b0;
            tick(2);
        end
        tick(10);
        check("t2_credits", int'(credits), 1);
        check("t2_fsm_idle", int'(u_dut.u_coin_deb.state), 0);

        // 3: fill to MAX, then a rejected coin
        clean_press(P_E, 4'd2);
        clean_press(P_E, 4'd3);
        clean_press(P_R, 4'd3);
        check("t3_credits", int'(credits), 3);

        // Coin at MAX with start: accepted, acked, stays at MAX
        coin_with_start(4'd3);

        // 4: drain, then nack, then coin and ack
        start_pulse(P_A, 4'd2);
        start_pulse(P_A, 4'd1);
        start_pulse(P_A, 4'd0);
        start_pulse(P_N, 4'd0);
        clean_press(P_E, 4'd1);
        start_pulse(P_A, 4'd0);

        // Coin with zero credits plus start: coin funds the game
        coin_with_start(4'd0);

        // 5: credits=2, coin + start together keeps 2
        clean_press(P_E, 4'd1);
        clean_press(P_E, 4'd2);
        coin_with_start(4'd2);
        check("t5_credits_kept", int'(credits), 2);
        arcade_sw = 1'b0;
        tick(3);
        check("t5_cleared", int'(credits), 0);
        check("t5_mode_off", int'(mode_arcade), 0);
        clean_press(4'b0000, 4'd0);
        start_pulse(P_A, 4'd0);
        start_pulse(P_A, 4'd0);
        check("t5_free_credits", int'(credits), 0);

        // 6: reset during PRESS_WAIT aborts the press
        arcade_sw = 1'b1;
        tick(4);
        clean_press(P_E, 4'd1);
        coin_btn = 1'b1;
        tick(4);
        check("t6_in_press_wait", int'(u_dut.u_coin_deb.state), 1);
        reset = 1'b1;
        coin_btn = 1'b0;
        #1;
        check("t6_rst_pulses", int'({e_piece, coin_reject, start_ack, start_nack}), 0);
        check("t6_rst_credits", int'(credits), 0);
        tick(2);
        reset = 1'b0;
        tick(20);
        check("t6_credits", int'(credits), 0);

        // Every expected pulse must have been seen
        check("sb_drained", sb_q.size(), 0);
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            $display("FAIL missing_pulse: got none expected code %0d at cycle %0d", e.pulses, e.cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
